regfile_param: RTL

REGFILE_PARAM -- requirements
Module: regfile_param

---
 rtl/regfile_param.sv | 131 +++++++++++++
 1 files changed

// File: rtl/regfile_param.sv
// Parametrised register file: two combinational read ports, one write port
// with per-entry write protection, optional write-to-read forwarding and a
// sequential clear engine that zeroes one entry per cycle.
module regfile_param #(
    parameter int unsigned                  DATA_W  = 10,
    parameter int unsigned                  ADDR_W  = 3,
    parameter logic [(1 << ADDR_W)-1:0]     WR_MASK = 8'h0F,
    parameter bit                           BYPASS  = 1'b1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [DATA_W-1:0] wdata,
    input  logic [ADDR_W-1:0] raddr1,
    input  logic [ADDR_W-1:0] raddr2,
    output logic [DATA_W-1:0] rdata1,
    output logic [DATA_W-1:0] rdata2,
    input  logic              clr_req,
    output logic              busy,
    output logic              wr_err,
    input  logic              err_clr
);

    localparam int unsigned DEPTH    = 1 << ADDR_W;
    localparam int unsigned LAST_IDX = DEPTH - 1;

    typedef enum logic {
        IDLE  = 1'b0,
        CLEAR = 1'b1
    } state_e;

    state_e              state_q, state_d;
    logic [ADDR_W-1:0]   idx_q, idx_d;
    logic [DATA_W-1:0]   mem_q [DEPTH];
    logic [DATA_W-1:0]   mem_d [DEPTH];
    logic                wr_err_q, wr_err_d;

    logic                wr_ok_c;
    logic                wr_bad_c;

    // Classify the current write attempt; writes during a clear are dropped.
    always_comb begin
        wr_ok_c  = 1'b0;
        wr_bad_c = 1'b0;
        if (we && (state_q == IDLE)) begin
            wr_ok_c  = WR_MASK[waddr];
            wr_bad_c = ~WR_MASK[waddr];
        end
    end

    // Next-state, clear sequencing, entry updates and sticky error flag.
    always_comb begin
        state_d  = state_q;
        idx_d    = idx_q;
        mem_d    = mem_q;
        wr_err_d = wr_err_q;

        unique case (state_q)
            IDLE: begin
                if (clr_req) begin
                    state_d = CLEAR;
                    idx_d   = '0;
                end
            end
            CLEAR: begin
                // Clear ignores protection; the last entry ends the sweep.
                mem_d[idx_q] = '0;
                idx_d        = idx_q + ADDR_W'(1);
                if (idx_q == ADDR_W'(LAST_IDX)) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        // A write coinciding with clr_req still lands; the sweep overwrites it later.
        if (wr_ok_c) begin
            mem_d[waddr] = wdata;
        end

        // A new violation wins over err_clr on the same edge.
        if (wr_bad_c) begin
            wr_err_d = 1'b1;
        end else if (err_clr) begin
            wr_err_d = 1'b0;
        end
    end

    // State, index and error flag registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            idx_q    <= '0;
            wr_err_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            idx_q    <= idx_d;
            wr_err_q <= wr_err_d;
        end
    end

    // Storage array; reset clears every entry immediately.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < int'(DEPTH); i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            for (int i = 0; i < int'(DEPTH); i++) begin
                mem_q[i] <= mem_d[i];
            end
        end
    end

    // Combinational reads with optional forwarding of an accepted write.
    always_comb begin
        rdata1 = mem_q[raddr1];
        rdata2 = mem_q[raddr2];
        if (BYPASS && wr_ok_c) begin
            if (waddr == raddr1) rdata1 = wdata;
            if (waddr == raddr2) rdata2 = wdata;
        end
    end

    assign busy   = (state_q == CLEAR);
    assign wr_err = wr_err_q;

endmodule
